// File: rtl/rpn_sequencer_if.sv
// rpn_sequencer_if: keypad op handshake, error status and operand-stack strobes/readback for rpn_sequencer.
interface rpn_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [3:0]       op_digit;
    logic             done;
    logic             err_flag;
    logic [1:0]       err_code;
    logic             stk_push;
    logic             stk_pop;
    logic             stk_write;
    logic [WIDTH-1:0] stk_value;
    logic [WIDTH-1:0] stk_top;
    logic [WIDTH-1:0] stk_next;
    logic [CNT_W-1:0] stk_count;
    logic             stk_error;

    modport master (
        input  op_valid, op_code, op_digit, stk_top, stk_next, stk_count, stk_error,
        output op_ready, done, err_flag, err_code, stk_push, stk_pop, stk_write, stk_value
    );

    modport slave (
        output op_valid, op_code, op_digit, stk_top, stk_next, stk_count, stk_error,
        input  op_ready, done, err_flag, err_code, stk_push, stk_pop, stk_write, stk_value
    );
endinterface

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: runs one keypad op at a time on the operand stack through registered push/pop/write strobes.
// Define RPN_DIV_EN to build the multi-cycle signed divider; without it DIV is rejected as an illegal op.
module rpn_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic            clock_i,
    input logic            reset_i,
    rpn_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, EXEC, POP, WRITE, PUSH, DIV, CLR, DONE} state_t;

    localparam logic [3:0] OP_DIGIT = 4'd1, OP_ENTER = 4'd2, OP_DROP = 4'd3, OP_ADD = 4'd4,
                           OP_SUB = 4'd5, OP_MUL = 4'd6, OP_DIV = 4'd7, OP_NEG = 4'd8, OP_CLEAR = 4'd9;
`ifdef RPN_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [3:0]       op_q, digit_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
    logic [CNT_W-1:0] c_q;
    logic             serr_q;
    logic             err_flag_q, err_flag_d;
    logic [1:0]       err_code_q, err_code_d, err_new;
    logic             done_q, push_q, pop_q, write_q;
    logic             accept, binary;

    assign accept = bus.op_valid && bus.op_ready;
    assign binary = op_q inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    assign err_new = ((binary || op_q == OP_DROP) && c_q == CNT_W'(1)) ? 2'd1 :
                     (serr_q || (op_q == OP_ENTER && c_q == '0)) ? 2'd2 :
                     (op_q > OP_CLEAR || (op_q == OP_DIV && (!DIV_EN || b_q == '0))) ? 2'd3 : 2'd0;

    assign bus.op_ready  = state_q == IDLE;
    assign bus.done      = done_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.err_code  = err_code_q;
    assign bus.stk_push  = push_q;
    assign bus.stk_pop   = pop_q;
    assign bus.stk_write = write_q;
    assign bus.stk_value = result_q;

`ifdef RPN_DIV_EN
    localparam int DW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [WIDTH:0]   trial;
    // restoring division on magnitudes; remainder stays below the divisor so WIDTH bits suffice
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
`endif

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        err_flag_d = err_flag_q;
        err_code_d = err_code_q;
`ifdef RPN_DIV_EN
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
`endif
        case (state_q)
            IDLE: state_d = accept ? EXEC : IDLE;
            EXEC: begin
                if (err_new != 2'd0) begin
                    state_d    = DONE;
                    err_flag_d = 1'b1;
                    err_code_d = err_flag_q ? err_code_q : err_new;
                end else begin
                    case (op_q)
                        OP_DIGIT: begin result_d = b_q * WIDTH'(10) + WIDTH'(digit_q); state_d = WRITE; end
                        OP_ENTER: state_d = PUSH;
                        OP_DROP:  state_d = POP;
                        OP_ADD:   begin result_d = a_q + b_q; state_d = POP; end
                        OP_SUB:   begin result_d = a_q - b_q; state_d = POP; end
                        OP_MUL:   begin result_d = a_q * b_q; state_d = POP; end
                        OP_NEG:   begin result_d = -b_q; state_d = WRITE; end
                        OP_CLEAR: begin
                            result_d   = '0;
                            err_flag_d = 1'b0;
                            err_code_d = 2'd0;
                            state_d    = c_q == CNT_W'(1) ? WRITE : CLR;
                        end
`ifdef RPN_DIV_EN
                        OP_DIV: begin
                            quo_d   = a_q[WIDTH-1] ? -a_q : a_q;
                            dvs_d   = b_q[WIDTH-1] ? -b_q : b_q;
                            rem_d   = '0;
                            cnt_d   = '0;
                            neg_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                            state_d = DIV;
                        end
`endif
                        default: state_d = DONE;
                    endcase
                end
            end
            POP:   state_d = op_q == OP_DROP ? DONE : WRITE;
            WRITE: state_d = DONE;
            PUSH:  state_d = DONE;
`ifdef RPN_DIV_EN
            DIV: begin
                if (cnt_q == DW'(WIDTH)) begin
                    result_d = neg_q ? -quo_q : quo_q;
                    state_d  = POP;
                end else begin
                    rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q + DW'(1);
                end
            end
`endif
            // count is live and pre-pop: the pop issued while it reads 2 leaves only the bottom entry
            CLR:   state_d = bus.stk_count inside {CNT_W'(1), CNT_W'(2)} ? WRITE : CLR;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            result_q   <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= 2'd0;
            done_q     <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            done_q     <= state_d == DONE;
            push_q     <= state_d == PUSH;
            pop_q      <= state_d inside {POP, CLR};
            write_q    <= state_d == WRITE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (accept) begin
            op_q    <= bus.op_code;
            digit_q <= bus.op_digit;
            a_q     <= bus.stk_next;
            b_q     <= bus.stk_top;
            c_q     <= bus.stk_count;
            serr_q  <= bus.stk_error;
        end
    end

`ifdef RPN_DIV_EN
    always_ff @(posedge clock_i) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        cnt_q <= cnt_d;
        neg_q <= neg_d;
    end
`endif
endmodule
